// File: rtl/uart_rx_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl_if
//   Frame hand-off bus between the UART frame controller and the command layer.
//   The controller holds one checked frame and offers it with a valid/ready
//   handshake. While the frame is offered, the consumer reads the payload
//   through a combinational index/data port.
//
//   Signals:
//     frame_valid  controller -> consumer  a checked frame is held
//     frame_ready  consumer -> controller  consumer accepts the held frame
//     frame_addr   controller -> consumer  ADDR byte of the held frame
//     frame_len    controller -> consumer  payload length of the held frame
//     rd_index     consumer -> controller  payload read index
//     rd_data      controller -> consumer  payload[rd_index]
//
//   Modports: master = frame controller, slave = command layer.
// ---------------------------------------------------------------------------
interface uart_rx_frame_ctrl_if #(
    parameter int MAX_LEN = 16
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);

    logic             frame_valid;
    logic             frame_ready;
    logic [7:0]       frame_addr;
    logic [LEN_W-1:0] frame_len;
    logic [IDX_W-1:0] rd_index;
    logic [7:0]       rd_data;

    modport master (
        output frame_valid, frame_addr, frame_len, rd_data,
        input  frame_ready, rd_index
    );

    modport slave (
        input  frame_valid, frame_addr, frame_len, rd_data,
        output frame_ready, rd_index
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
//   Sits behind the UART receiver and turns its byte stream into frames of
//   the form SYNC, ADDR, LEN, PAYLOAD[LEN], CHECKSUM. The checksum byte makes
//   the 8-bit sum of ADDR, LEN, the payload and the checksum itself equal to
//   zero. SYNC is not part of the sum. One validated frame is stored and
//   offered to the command layer. Malformed, stalled or overrunning traffic
//   is dropped and flagged with a one-cycle error pulse.
//
//   Ports:
//     uart_clk      single clock
//     reset_n       asynchronous active-low reset
//     rx_data       received byte, meaningful only while rx_strobe is high
//     rx_strobe     one-cycle byte-received pulse
//     frame_if      frame hand-off bus (master side)
//     err_checksum  pulse: frame discarded because its checksum is wrong
//     err_length    pulse: LEN byte exceeded MAX_LEN
//     err_timeout   pulse: inter-byte gap too long inside a frame
//     err_overrun   pulse: byte arrived while a frame was still held
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
    parameter int         CLOCK_FREQUENCY = 12_000_000,
    parameter int         BAUD_RATE       = 115_200,
    parameter int         MAX_LEN         = 16,
    parameter logic [7:0] SYNC_BYTE       = 8'hA5,
    parameter int         TIMEOUT_BYTES   = 4
) (
    input  logic                 uart_clk,
    input  logic                 reset_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_strobe,
    uart_rx_frame_ctrl_if.master frame_if,
    output logic                 err_checksum,
    output logic                 err_length,
    output logic                 err_timeout,
    output logic                 err_overrun
);
    localparam int CLOCKS_PER_BAUD = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int TIMEOUT_CLKS    = TIMEOUT_BYTES * 10 * CLOCKS_PER_BAUD;
    localparam int TMO_W           = $clog2(TIMEOUT_CLKS);
    localparam int LEN_W           = $clog2(MAX_LEN + 1);
    localparam int IDX_W           = $clog2(MAX_LEN);

    localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]       MAX_LEN_B  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ADDR,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       sum_q, sum_d, sum_next;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             err_checksum_d, err_length_d, err_timeout_d, err_overrun_d;
    logic             wr_en;
    logic [7:0]       buffer [MAX_LEN];

    // State and datapath register; errors are registered so each pulse is one clean cycle
    always_ff @(posedge uart_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HUNT;
            sum_q        <= '0;
            tmo_q        <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            err_checksum <= 1'b0;
            err_length   <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            tmo_q        <= tmo_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            err_checksum <= err_checksum_d;
            err_length   <= err_length_d;
            err_timeout  <= err_timeout_d;
            err_overrun  <= err_overrun_d;
        end
    end

    // Payload storage has no reset; its contents only matter once a frame is held
    always_ff @(posedge uart_clk) begin
        if (wr_en) begin
            buffer[idx_q] <= rx_data;
        end
    end

    assign sum_next = sum_q + rx_data;

    // Next-state logic. Inside a frame, an arriving byte always beats the
    // timeout, and the counter only runs down on cycles with no byte.
    always_comb begin
        state_d        = state_q;
        sum_d          = sum_q;
        tmo_d          = tmo_q;
        idx_d          = idx_q;
        addr_d         = addr_q;
        len_d          = len_q;
        err_checksum_d = 1'b0;
        err_length_d   = 1'b0;
        err_timeout_d  = 1'b0;
        err_overrun_d  = 1'b0;
        wr_en          = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (rx_strobe && rx_data == SYNC_BYTE) begin
                    sum_d   = '0;
                    tmo_d   = TMO_RELOAD;
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CHECK: begin
                if (rx_strobe) begin
                    tmo_d = TMO_RELOAD;
                    case (state_q)
                        ST_ADDR: begin
                            addr_d  = rx_data;
                            sum_d   = sum_next;
                            state_d = ST_LEN;
                        end
                        ST_LEN: begin
                            if (rx_data > MAX_LEN_B) begin
                                err_length_d = 1'b1;
                                state_d      = ST_HUNT;
                            end else begin
                                len_d   = rx_data[LEN_W-1:0];
                                sum_d   = sum_next;
                                idx_d   = '0;
                                state_d = (rx_data == 8'h00) ? ST_CHECK : ST_PAYLOAD;
                            end
                        end
                        ST_PAYLOAD: begin
                            wr_en = 1'b1;
                            sum_d = sum_next;
                            idx_d = idx_q + IDX_W'(1);
                            if (LEN_W'(idx_q) == len_q - LEN_W'(1)) begin
                                state_d = ST_CHECK;
                            end
                        end
                        default: begin
                            if (sum_next == 8'h00) begin
                                state_d = ST_HOLD;
                            end else begin
                                err_checksum_d = 1'b1;
                                state_d        = ST_HUNT;
                            end
                        end
                    endcase
                end else if (tmo_q == '0) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_HUNT;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end

            ST_HOLD: begin
                // An accept in the same cycle as a byte frees the buffer, so the
                // byte is treated as the first byte of a hunt instead of an overrun.
                if (frame_if.frame_ready) begin
                    state_d = ST_HUNT;
                    if (rx_strobe && rx_data == SYNC_BYTE) begin
                        sum_d   = '0;
                        tmo_d   = TMO_RELOAD;
                        state_d = ST_ADDR;
                    end
                end else if (rx_strobe) begin
                    err_overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    assign frame_if.frame_valid = (state_q == ST_HOLD);
    assign frame_if.frame_addr  = addr_q;
    assign frame_if.frame_len   = len_q;
    assign frame_if.rd_data     = buffer[frame_if.rd_index];
endmodule
